// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word
// requests to instruction memory, buffers returned words in a 2-entry
// prefetch FIFO and presents one instruction per cycle (with PC and PC+4) to
// decode. Honours decode freeze and branch/jump redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Alt_PC,
    input  logic        Request_Alt_PC,
    input  logic        WANT_FREEZE,
    output logic        IMEM_Req,
    output logic [31:0] IMEM_Addr,
    input  logic        IMEM_Ack,
    input  logic [31:0] IMEM_Data,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    // Fetch PC, request (doubles as the outstanding flag) and squash state
    logic [XLEN-1:0]  r_pc;
    logic             r_req;
    logic [XLEN-1:0]  r_addr;
    logic             r_squash;

    // Prefetch FIFO of {instr, pc}
    logic [XLEN-1:0]  r_fifo_instr [DEPTH];
    logic [XLEN-1:0]  r_fifo_pc    [DEPTH];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    // Decode-facing output registers
    logic [XLEN-1:0]  r_instr;
    logic [XLEN-1:0]  r_ipc;
    logic [XLEN-1:0]  r_ipc4;

    logic             w_ack;
    logic             w_push;
    logic             w_pop;
    logic             w_busy_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_issue;
    logic [XLEN-1:0]  w_fetch_pc;

    // An ack only counts while a request is actually outstanding, so a stale
    // ack arriving after reset is ignored.
    assign w_ack       = IMEM_Ack & r_req;
    assign w_push      = w_ack & ~r_squash & ~Request_Alt_PC;
    assign w_pop       = ~WANT_FREEZE & ~Request_Alt_PC & (r_count != CNT_W'(0));
    assign w_busy_nxt  = r_req & ~IMEM_Ack;
    assign w_fetch_pc  = Request_Alt_PC ? (Alt_PC & ~XLEN'(3)) : r_pc;

    // FIFO occupancy after this edge's flush/push/pop
    always_comb begin
        w_count_nxt = r_count;
        if (Request_Alt_PC) begin
            w_count_nxt = CNT_W'(0);
        end else begin
            w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Issue only when the slot we would fill is guaranteed room in the FIFO
    assign w_issue = ~w_busy_nxt & (w_count_nxt <= CNT_W'(1));

    // Request channel, fetch PC and squash tracking
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pc     <= RESET_PC;
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_squash <= 1'b0;
        end else begin
            if (w_issue) begin
                r_req  <= 1'b1;
                r_addr <= w_fetch_pc;
                r_pc   <= w_fetch_pc + XLEN'(4);
            end else begin
                r_req <= w_busy_nxt;
                if (Request_Alt_PC) begin
                    r_pc <= w_fetch_pc;
                end
            end
            if (Request_Alt_PC && w_busy_nxt) begin
                r_squash <= 1'b1;
            end else if (w_ack) begin
                r_squash <= 1'b0;
            end
        end
    end

    // Prefetch FIFO storage and pointers; redirect flushes it
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (Request_Alt_PC) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_fifo_instr[r_wr_ptr] <= IMEM_Data;
                    r_fifo_pc[r_wr_ptr]    <= r_addr;
                    r_wr_ptr               <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
            r_count <= w_count_nxt;
        end
    end

    // Decode outputs: hold on freeze, else pop the head or present a nop
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_instr <= '0;
            r_ipc   <= '0;
            r_ipc4  <= '0;
        end else if (!WANT_FREEZE) begin
            if (w_pop) begin
                r_instr <= r_fifo_instr[r_rd_ptr];
                r_ipc   <= r_fifo_pc[r_rd_ptr];
                r_ipc4  <= r_fifo_pc[r_rd_ptr] + XLEN'(4);
            end else begin
                r_instr <= '0;
                r_ipc   <= '0;
                r_ipc4  <= '0;
            end
        end
    end

    assign IMEM_Req           = r_req;
    assign IMEM_Addr          = r_addr;
    assign Instr1_OUT         = r_instr;
    assign Instr_PC_OUT       = r_ipc;
    assign Instr_PC_Plus4_OUT = r_ipc4;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: memory model with random latency, random
// freeze/redirect stimulus, and a scoreboard of the expected program stream.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;
    localparam logic [31:0] DMASK    = 32'hA5A5A5A5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Alt_PC;
    logic        Request_Alt_PC;
    logic        WANT_FREEZE;
    logic        IMEM_Req;
    logic [31:0] IMEM_Addr;
    logic        IMEM_Ack;
    logic [31:0] IMEM_Data;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4_OUT;

    always #5 CLK = ~CLK;

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .Alt_PC             (Alt_PC),
        .Request_Alt_PC     (Request_Alt_PC),
        .WANT_FREEZE        (WANT_FREEZE),
        .IMEM_Req           (IMEM_Req),
        .IMEM_Addr          (IMEM_Addr),
        .IMEM_Ack           (IMEM_Ack),
        .IMEM_Data          (IMEM_Data),
        .Instr1_OUT         (Instr1_OUT),
        .Instr_PC_OUT       (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT (Instr_PC_Plus4_OUT)
    );

    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_present = 0;
    bit          done = 1'b0;

    // Expected program-order PCs still to be presented to decode
    logic [31:0] exp_q[$];
    logic [31:0] next_push;

    // Memory model state
    int          lat_mode;
    bit          mem_pend;
    int          mem_cnt;

    // Monitor state
    logic [31:0] p_i, p_pc, p_p4, p_addr, e_pc;
    bit          p_req;
    int          idle;

    logic [31:0] alt;
    bit          found;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_push);
            next_push = next_push + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        next_push = pc;
        refill();
    endtask

    task automatic do_redirect(input logic [31:0] a);
        Alt_PC         = a;
        Request_Alt_PC = 1'b1;
        restart({a[31:2], 2'b00});
    endtask

    // Memory: acks each request after 0..3 cycles with data = addr ^ mask
    task automatic mem_update();
        if (IMEM_Ack) mem_pend = 1'b0;
        IMEM_Ack  = 1'b0;
        IMEM_Data = $urandom;
        if (RESET) begin
            mem_pend = 1'b0;
        end else begin
            if (IMEM_Req && !mem_pend) begin
                mem_pend = 1'b1;
                mem_cnt  = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
            end
            if (mem_pend) begin
                if (mem_cnt == 0) begin
                    IMEM_Ack  = 1'b1;
                    IMEM_Data = IMEM_Addr ^ DMASK;
                end else begin
                    mem_cnt--;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        Request_Alt_PC = 1'b0;
        mem_update();
        refill();
    endtask

    // Monitor: checks the value loaded at each edge against the scoreboard
    initial begin
        p_i = '0; p_pc = '0; p_p4 = '0; p_addr = '0; p_req = 1'b0; idle = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (done) break;
            if (RESET) begin
                chk("rst_req", 32'(IMEM_Req), 32'd0);
                chk("rst_instr", Instr1_OUT | Instr_PC_OUT | Instr_PC_Plus4_OUT, 32'd0);
                p_i = '0; p_pc = '0; p_p4 = '0; p_req = 1'b0; idle = 0;
            end else begin
                if (WANT_FREEZE) begin
                    chk("hold_instr", Instr1_OUT, p_i);
                    chk("hold_pc", Instr_PC_OUT, p_pc);
                    chk("hold_pc4", Instr_PC_Plus4_OUT, p_p4);
                end else if (Request_Alt_PC) begin
                    chk("redir_nop", Instr1_OUT | Instr_PC_OUT | Instr_PC_Plus4_OUT, 32'd0);
                    idle = 0;
                end else if (Instr1_OUT != 32'd0) begin
                    idle = 0;
                    n_present++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_instr", Instr_PC_OUT, 32'hxxxxxxxx);
                    end else begin
                        e_pc = exp_q.pop_front();
                        chk("pc", Instr_PC_OUT, e_pc);
                        chk("instr", Instr1_OUT, e_pc ^ DMASK);
                        chk("pc_plus4", Instr_PC_Plus4_OUT, e_pc + 32'd4);
                    end
                end else begin
                    chk("nop_pc", Instr_PC_OUT | Instr_PC_Plus4_OUT, 32'd0);
                    idle++;
                    if (idle > 60) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL watchdog: no instruction for %0d cycles, expected pc %h", idle, exp_q[0]);
                        idle = 0;
                    end
                end
                if (p_req && !IMEM_Ack) begin
                    chk("req_held", 32'(IMEM_Req), 32'd1);
                    chk("addr_stable", IMEM_Addr, p_addr);
                end
                p_i = Instr1_OUT; p_pc = Instr_PC_OUT; p_p4 = Instr_PC_Plus4_OUT;
                p_req = IMEM_Req; p_addr = IMEM_Addr;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1; Alt_PC = '0; Request_Alt_PC = 1'b0; WANT_FREEZE = 1'b0;
        IMEM_Ack = 1'b0; IMEM_Data = '0; lat_mode = 1; mem_pend = 1'b0; mem_cnt = 0;
        restart(RESET_PC);
        repeat (3) step();
        chk("init_rst_addr", IMEM_Addr, 32'd0);

        // Reset release and sequential stream with 1-cycle memory
        RESET = 1'b0;
        restart(RESET_PC);
        step();
        chk("first_req", 32'(IMEM_Req), 32'd1);
        chk("first_addr", IMEM_Addr, RESET_PC);
        repeat (24) step();
        chk("stream_progress", 32'(n_present >= 3), 32'd1);

        // Freeze with instant memory: buffer fills, requests stop
        lat_mode = 0;
        repeat (6) step();
        WANT_FREEZE = 1'b1;
        repeat (5) step();
        chk("freeze_req_low", 32'(IMEM_Req), 32'd0);
        WANT_FREEZE = 1'b0;
        repeat (10) step();

        // Reset mid-request, stale ack after release
        lat_mode = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (IMEM_Req && mem_cnt > 0) found = 1'b1;
        end
        chk("outstanding_found", 32'(found), 32'd1);
        RESET = 1'b1;
        #1;
        chk("async_rst_req", 32'(IMEM_Req), 32'd0);
        chk("async_rst_out", Instr1_OUT | Instr_PC_OUT, 32'd0);
        step();
        step();
        RESET     = 1'b0;
        IMEM_Ack  = 1'b1;
        IMEM_Data = 32'h12345678;
        restart(RESET_PC);
        step();
        chk("post_rst_req", 32'(IMEM_Req), 32'd1);
        chk("post_rst_addr", IMEM_Addr, RESET_PC);

        // Redirect while the request to BFC00010 is outstanding
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (IMEM_Req && IMEM_Addr == 32'hBFC00010) found = 1'b1;
        end
        chk("bfc00010_found", 32'(found), 32'd1);
        do_redirect(32'h00400103);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (IMEM_Addr != 32'hBFC00010) found = 1'b1;
        end
        chk("redir_req", 32'(IMEM_Req), 32'd1);
        chk("redir_addr", IMEM_Addr, 32'h00400100);
        repeat (20) step();

        // Redirect coincident with ack and freeze
        lat_mode = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (IMEM_Ack) begin
                found = 1'b1;
                WANT_FREEZE = 1'b1;
                do_redirect(32'h10000000);
            end
        end
        step();
        chk("rfa_found", 32'(found), 32'd1);
        chk("rfa_req", 32'(IMEM_Req), 32'd1);
        chk("rfa_addr", IMEM_Addr, 32'h10000000);
        WANT_FREEZE = 1'b0;
        repeat (12) step();

        // Address wrap at the top of the address space
        lat_mode = 0;
        step();
        do_redirect(32'hFFFFFFF8);
        repeat (16) step();

        // Randomized traffic
        lat_mode = -1;
        repeat (1500) begin
            step();
            WANT_FREEZE = ($urandom_range(3, 0) == 0);
            if ($urandom_range(24, 0) == 0) begin
                case ($urandom_range(3, 0))
                    0:       alt = 32'hFFFFFFF4;
                    1:       alt = 32'h00400000 | ($urandom & 32'h0000FFFF);
                    default: alt = $urandom;
                endcase
                do_redirect(alt);
            end
        end
        WANT_FREEZE = 1'b0;
        repeat (30) step();

        done = 1'b1;
        @(posedge CLK);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
